pipe_ctrl_unit: RTL and testbench

Parametrised pipeline sequencer for the N-stage MIPS/DLX core. It owns the per-latch valid bits, the PC and latch enables, and load-use stall and branch-flush handling. It also provides a RUN/DRAIN/HALTED/STEP run-control FSM for single-stepping from the bench or a debug port. It sits beside the datapath; every pipeline latch's enable and valid qualifier comes from here.

---
 rtl/pipe_ctrl_unit_if.sv | 44 ++++
 rtl/pipe_ctrl_unit.sv | 106 ++++++++++
 tb/tb_pipe_ctrl_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - control/status bundle between the datapath and the pipeline sequencer
interface pipe_ctrl_unit_if #(
  parameter int N_STAGES   = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  localparam int L = N_STAGES - 1;

  // Datapath and debug requests into the sequencer
  logic                  instr_valid_in;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] ex_rw;
  logic                  ex_mem_read;
  logic                  branch_taken;
  logic                  halt_req;
  logic                  step_req;
  logic                  run_req;

  // Enables, qualifiers and status out of the sequencer
  logic                  pc_en;
  logic [L-1:0]          latch_en;
  logic [L-1:0]          valid_out;
  logic                  stall;
  logic                  retire;
  logic [1:0]            state;
  logic [CNT_W-1:0]      cycle_count;
  logic [CNT_W-1:0]      retired_count;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output instr_valid_in, id_rs, id_rt, ex_rw, ex_mem_read,
           branch_taken, halt_req, step_req, run_req,
    input  pc_en, latch_en, valid_out, stall, retire, state,
           cycle_count, retired_count, stall_count
  );

  modport slave (
    input  instr_valid_in, id_rs, id_rt, ex_rw, ex_mem_read,
           branch_taken, halt_req, step_req, run_req,
    output pc_en, latch_en, valid_out, stall, retire, state,
           cycle_count, retired_count, stall_count
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipeline sequencer with load-use stall, branch flush, run control (PIPE_PERF_CNT_EN enables perf counters)
module pipe_ctrl_unit #(
  parameter int N_STAGES   = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input logic              clock,
  input logic              reset,
  pipe_ctrl_unit_if.slave  bus
);
  localparam int L = N_STAGES - 1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_STEP   = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [L-1:0] valid_q, valid_d;
  logic         stall;
  logic         halted;
  logic         fetch_ok;

  // Hazard detect and run-state decode
  always_comb begin
    halted   = (state_q == ST_HALTED);
    fetch_ok = (state_q == ST_RUN) || (state_q == ST_STEP);
    stall    = valid_q[0] & valid_q[1] & bus.ex_mem_read &
               (bus.ex_rw != '0) &
               ((bus.ex_rw == bus.id_rs) | (bus.ex_rw == bus.id_rt));
  end

  // Valid-bit shift: a stall holds IF/ID and injects a bubble into EX
  always_comb begin
    valid_d = valid_q;
    if (!halted) begin
      for (int i = 2; i < L; i++) begin
        valid_d[i] = valid_q[i-1];
      end
      if (stall) begin
        valid_d[1] = 1'b0;
      end else begin
        valid_d[1] = valid_q[0];
        valid_d[0] = fetch_ok & bus.instr_valid_in & ~bus.branch_taken;
      end
    end
  end

  // Run-control next state; STEP leaves only once its fetch has gone through
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (bus.halt_req) state_d = ST_DRAIN;
      ST_DRAIN:  if (valid_q == '0) state_d = ST_HALTED;
      ST_HALTED: begin
        if (bus.run_req)       state_d = ST_RUN;
        else if (bus.step_req) state_d = ST_STEP;
      end
      default:   if (!stall) state_d = ST_DRAIN;
    endcase
  end

  // State and valid registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.pc_en     = fetch_ok & ~stall;
  assign bus.latch_en  = halted ? '0 : (stall ? {{(L-1){1'b1}}, 1'b0} : '1);
  assign bus.retire    = ~halted & valid_q[L-1];
  assign bus.state     = state_q;
  assign bus.valid_out = valid_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, retired_cnt_q, stall_cnt_q;

  // Saturating performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (!halted && !(&cycle_cnt_q))     cycle_cnt_q   <= cycle_cnt_q + CNT_W'(1);
      if (bus.retire && !(&retired_cnt_q)) retired_cnt_q <= retired_cnt_q + CNT_W'(1);
      if (stall && !(&stall_cnt_q))        stall_cnt_q   <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.cycle_count   = cycle_cnt_q;
  assign bus.retired_count = retired_cnt_q;
  assign bus.stall_count   = stall_cnt_q;
`else
  assign bus.cycle_count   = '0;
  assign bus.retired_count = '0;
  assign bus.stall_count   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;
  localparam int N_STAGES   = 5;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 32;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  pipe_ctrl_unit_if #(.N_STAGES(N_STAGES), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

  pipe_ctrl_unit #(.N_STAGES(N_STAGES), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cexp(input int v);
    return PERF ? 64'(v) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.instr_valid_in = 1'b0;
    bus.id_rs = '0; bus.id_rt = '0; bus.ex_rw = '0;
    bus.ex_mem_read = 1'b0; bus.branch_taken = 1'b0;
    bus.halt_req = 1'b0; bus.step_req = 1'b0; bus.run_req = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    for (int i = 0; i < 20 && bus.state != 2'd2; i++) tick();
    check(tag, bus.state, 2);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_valid", bus.valid_out, 4'b0000);
    check("rst_state", bus.state, 0);
    check("rst_pc_en", bus.pc_en, 1);
    check("rst_latch_en", bus.latch_en, 4'b1111);
    check("rst_stall", bus.stall, 0);
    check("rst_retire", bus.retire, 0);
    check("rst_cyc", bus.cycle_count, 0);
    check("rst_ret", bus.retired_count, 0);
    check("rst_stl", bus.stall_count, 0);

    // Straight-line fill: 11 fetch cycles (cycles 0..10)
    bus.instr_valid_in = 1'b1;
    tick(); tick(); tick();
    check("fill3_valid", bus.valid_out, 4'b0111);
    check("fill3_retire", bus.retire, 0);
    tick();
    check("fill4_valid", bus.valid_out, 4'b1111);
    check("fill4_retire", bus.retire, 1);
    for (int i = 0; i < 7; i++) tick();
    check("fill_ret_cnt", bus.retired_count, cexp(7));
    check("fill_cyc_cnt", bus.cycle_count, cexp(11));

    // Load-use hazard on rs
    bus.ex_mem_read = 1'b1; bus.ex_rw = 5'd5; bus.id_rs = 5'd5;
    #1;
    check("lu_stall", bus.stall, 1);
    check("lu_pc_en", bus.pc_en, 0);
    check("lu_latch_en", bus.latch_en, 4'b1110);
    tick();
    clear_inputs(); bus.instr_valid_in = 1'b1;
    #1;
    check("lu_valid", bus.valid_out, 4'b1101);
    check("lu_stall_cnt", bus.stall_count, cexp(1));
    check("lu_stall_clr", bus.stall, 0);
    tick();
    check("lu_refill", bus.valid_out, 4'b1011);
    // ex_rw = 0 never stalls, even if it matches
    bus.ex_mem_read = 1'b1; bus.ex_rw = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    #1;
    check("lu_r0_stall", bus.stall, 0);
    check("lu_r0_pc_en", bus.pc_en, 1);
    bus.ex_rw = 5'd5; bus.id_rt = 5'd5;
    #1;
    check("lu_rt_stall", bus.stall, 1);
    clear_inputs(); bus.instr_valid_in = 1'b1;

    // Taken branch flushes IF/ID
    bus.branch_taken = 1'b1;
    #1;
    check("br_pc_en", bus.pc_en, 1);
    check("br_stall", bus.stall, 0);
    tick();
    bus.branch_taken = 1'b0;
    check("br_valid", bus.valid_out, 4'b0110);
    tick(); tick();
    check("br_refill", bus.valid_out, 4'b1011);
    // Branch during a stall: stall wins
    bus.branch_taken = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rw = 5'd7; bus.id_rs = 5'd7;
    #1;
    check("brst_stall", bus.stall, 1);
    tick();
    clear_inputs(); bus.instr_valid_in = 1'b1;
    check("brst_valid", bus.valid_out, 4'b0101);
    check("brst_stall_cnt", bus.stall_count, cexp(2));

    // Halt from a full pipe
    reset = 1'b1; tick(); reset = 1'b0;
    tick(); tick(); tick(); tick();
    check("h_full", bus.valid_out, 4'b1111);
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    #1;
    check("h_state_drain", bus.state, 1);
    check("h_drain_valid", bus.valid_out, 4'b1111);
    check("h_drain_pc_en", bus.pc_en, 0);
    wait_halted("h_reach_halted");
    check("h_valid", bus.valid_out, 4'b0000);
    check("h_latch_en", bus.latch_en, 4'b0000);
    check("h_pc_en", bus.pc_en, 0);
    check("h_ret_cnt", bus.retired_count, cexp(5));
    check("h_cyc_cnt", bus.cycle_count, cexp(10));
    bus.halt_req = 1'b1;
    tick(); tick(); tick();
    check("h_hold_state", bus.state, 2);
    check("h_cyc_frozen", bus.cycle_count, cexp(10));
    bus.halt_req = 1'b0;

    // Single step
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    #1;
    check("s_state_step", bus.state, 3);
    check("s_pc_en", bus.pc_en, 1);
    tick();
    check("s_state_drain", bus.state, 1);
    check("s_valid", bus.valid_out, 4'b0001);
    wait_halted("s_reach_halted");
    check("s_valid_end", bus.valid_out, 4'b0000);
    check("s_ret_cnt", bus.retired_count, cexp(6));
    check("s_cyc_cnt", bus.cycle_count, cexp(16));
    bus.run_req = 1'b1; bus.step_req = 1'b1;
    tick();
    bus.run_req = 1'b0; bus.step_req = 1'b0;
    check("run_prio", bus.state, 0);

    // Reset in the middle of a drain
    tick(); tick();
    bus.instr_valid_in = 1'b0; bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    check("rd_state", bus.state, 1);
    check("rd_valid", bus.valid_out, 4'b0110);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rd_state_rst", bus.state, 0);
    check("rd_valid_rst", bus.valid_out, 4'b0000);
    check("rd_cyc_rst", bus.cycle_count, 0);
    check("rd_ret_rst", bus.retired_count, 0);
    check("rd_stl_rst", bus.stall_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
